// File: rtl/alu_cmd_seq.sv
// Command sequencer for the 4-bit ALU: buffers commands, fetches operands from a
// 4x4 register file, drives the ALU and writes the result and flags back.
module alu_cmd_seq #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [1:0] cmd_rd,
    input  logic [1:0] cmd_rs1,
    input  logic [1:0] cmd_rs2,
    input  logic       cmd_imm_en,
    input  logic [3:0] cmd_imm,
    input  logic       hold,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [2:0] alu_sel,
    input  logic [3:0] alu_out,
    input  logic       alu_cf,
    input  logic       alu_of,
    input  logic       alu_zf,
    output logic       res_valid,
    output logic [3:0] res_data,
    output logic [1:0] res_rd,
    output logic [2:0] flags,
    output logic       busy,
    input  logic [1:0] dbg_addr,
    output logic [3:0] dbg_data
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_EXEC = 1'b1
    } state_t;

    typedef struct packed {
        logic [2:0] op;
        logic [1:0] rd;
        logic [1:0] rs1;
        logic [1:0] rs2;
        logic       imm_en;
        logic [3:0] imm;
    } cmd_t;

    state_t          r_state;
    cmd_t            r_mem [DEPTH];
    cmd_t            r_ir;
    logic [AW-1:0]   r_head;
    logic [AW-1:0]   r_tail;
    logic [CW-1:0]   r_count;
    logic [3:0]      r_rf [4];
    logic [2:0]      r_flags;
    logic            r_res_valid;
    logic [3:0]      r_res_data;
    logic [1:0]      r_res_rd;

    logic            w_push;
    logic            w_pop;
    logic            w_exec;
    logic            w_arith;
    cmd_t            w_entry;

    assign w_entry   = '{op: cmd_op, rd: cmd_rd, rs1: cmd_rs1, rs2: cmd_rs2,
                         imm_en: cmd_imm_en, imm: cmd_imm};
    assign cmd_ready = rst_n && (r_count != FULL);
    assign w_push    = cmd_valid && cmd_ready;
    // A fresh push is only visible through r_count on the next cycle: no bypass.
    assign w_pop     = (r_count != '0) && !hold;
    assign w_exec    = (r_state == S_EXEC);
    assign w_arith   = (r_ir.op[2:1] == 2'b00);

    always_comb begin
        alu_sel = '0;
        alu_a   = '0;
        alu_b   = '0;
        if (w_exec) begin
            alu_sel = r_ir.op;
            alu_a   = r_rf[r_ir.rs1];
            alu_b   = r_ir.imm_en ? r_ir.imm : r_rf[r_ir.rs2];
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_tail] <= w_entry;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_ir        <= '0;
            r_head      <= '0;
            r_tail      <= '0;
            r_count     <= '0;
            r_flags     <= '0;
            r_res_valid <= 1'b0;
            r_res_data  <= '0;
            r_res_rd    <= '0;
            for (int i = 0; i < 4; i++) begin
                r_rf[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_tail <= r_tail + 1'b1;
            end
            if (w_pop) begin
                r_ir   <= r_mem[r_head];
                r_head <= r_head + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase

            r_state     <= w_pop ? S_EXEC : S_IDLE;
            r_res_valid <= w_exec;
            // Writeback and next IR load share this edge, so dependent ops need no stall.
            if (w_exec) begin
                r_rf[r_ir.rd] <= alu_out;
                r_flags       <= {w_arith & alu_cf, w_arith & alu_of, alu_zf};
                r_res_data    <= alu_out;
                r_res_rd      <= r_ir.rd;
            end
        end
    end

    assign res_valid = r_res_valid;
    assign res_data  = r_res_data;
    assign res_rd    = r_res_rd;
    assign flags     = r_flags;
    assign busy      = w_exec || (r_count != '0);
    assign dbg_data  = r_rf[dbg_addr];

endmodule

// File: doc/alu_cmd_seq.md
# alu_cmd_seq

Command sequencer that sits directly upstream of the 4-bit ALU. It accepts ALU commands over a valid/ready handshake and buffers them in a small FIFO. It reads operands from a 4-entry × 4-bit register file, drives the combinational ALU's `a`/`b`/`sel` inputs, and writes the ALU result back into the register file. It also latches the ALU flags and reports each completed operation with a one-cycle result pulse.

## Interface
- `DEPTH`, default 4: command FIFO entries; must be a power of 2 and at least 2.
- `clk` input 1: sole clock; all state updates on the rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `cmd_valid` input 1: command present.
- `cmd_ready` output 1: FIFO can accept; equals FIFO not full.
- `cmd_op` input 3: ALU select; 000 add, 001 sub, 010 not, 011 and, 100 or, 101 xor, 110 signed less-than, 111 equal.
- `cmd_rd` input 2: destination register.
- `cmd_rs1` input 2: source register for operand a.
- `cmd_rs2` input 2: source register for operand b, used when `cmd_imm_en`=0.
- `cmd_imm_en` input 1: when 1, operand b is `cmd_imm`.
- `cmd_imm` input 4: immediate operand.
- `hold` input 1: while 1, no new command leaves the FIFO.
- `alu_a`, `alu_b` output 4: operands to the ALU.
- `alu_sel` output 3: op to the ALU.
- `alu_out` input 4: ALU result.
- `alu_cf`, `alu_of`, `alu_zf` input 1: ALU flags.
- `res_valid` output 1: one-cycle pulse, one per completed command.
- `res_data` output 4: value written by the completed command.
- `res_rd` output 2: register written by the completed command.
- `flags` output 3: registered {cf, of, zf}.
- `busy` output 1: FSM in EXEC or FIFO non-empty.
- `dbg_addr` input 2: register file read address.
- `dbg_data` output 4: combinational read of `rf[dbg_addr]`.

## Operation
- **Command FIFO**
  - A 14-bit entry {op, rd, rs1, rs2, imm_en, imm} is pushed when `cmd_valid && cmd_ready`.
  - Head and tail pointers are log2(DEPTH) bits and wrap modulo DEPTH; an occupancy count is 0..DEPTH.
  - When full, `cmd_ready`=0 even if a pop happens in the same cycle; there is no full pass-through.
  - A push into an empty FIFO is not poppable until the next cycle; there is no bypass.
  - A simultaneous push and pop leaves the count unchanged.
- **FSM states: IDLE, EXEC**
  - IDLE → EXEC when FIFO non-empty and `hold`=0; the head is popped into the instruction register (IR) at that edge.
  - EXEC → EXEC when FIFO non-empty and `hold`=0, popping the next head at the same edge. Otherwise EXEC → IDLE.
  - `hold` never aborts an instruction already in EXEC.
- **ALU drive**
  - In EXEC: `alu_sel`=IR.op, `alu_a`=rf[IR.rs1], `alu_b` = IR.imm_en ? IR.imm : rf[IR.rs2].
  - In IDLE all three ALU outputs are 0.
- **Writeback at the end of EXEC**
  - rf[IR.rd] ← `alu_out`.
  - zf ← `alu_zf`.
  - cf ← `alu_cf` and of ← `alu_of` for op 000/001; cf ← 0 and of ← 0 for all other ops.
  - `res_valid` ← 1, `res_data` ← `alu_out`, `res_rd` ← IR.rd.
- **Hazards**
  - Back-to-back dependent commands need no interlock: the RF write and the next IR load occur on the same edge, and the next EXEC reads the updated RF.
- **Register file**
  - 4 × 4 bits, all registers writable; no hardwired zero.

## Timing
- **Reset (`rst_n`=0 at an edge)**
  - FSM → IDLE; FIFO emptied; pointers and count → 0.
  - rf[0..3] → 0, flags → 000, `res_valid` → 0, `res_data` → 0, `res_rd` → 0.
  - `cmd_ready` is 0 while `rst_n`=0.
- **Reset mid-EXEC:** the in-flight command is discarded; no writeback and no `res_valid`.
- **Latency:** a command accepted at edge 0 into an empty FIFO with FSM in IDLE is popped at edge 1, is in EXEC during cycle 1→2, writes back at edge 2, and gives `res_valid`=1 in cycle 2→3.
- **Throughput:** 1 command per cycle when the FIFO is not starved.
- **`res_valid` pulse:** high exactly 1 cycle per command. `res_data`, `res_rd` and `flags` hold their values until the next writeback.
- **`busy`:** registered-state derived; falls in the cycle after the last EXEC.

## Test plan
- **Reset:** assert `rst_n`=0 for 2 cycles with 3 commands queued and FSM in EXEC → after release, `cmd_ready`=1, `busy`=0, `flags`=000, `dbg_data`=0 at all 4 addresses, no `res_valid` pulse.
- **Load and add:**
  - Stimulus: (or, rd=1, rs1=0, imm 7), then (add, rd=2, rs1=1, imm 1), issued back-to-back.
  - Response: `res_valid` in cycles 3 and 4 with `res_data` 7 then 8; rf[2]=8; `flags`.of=1, `flags`.zf=0.
  - Shows RAW forwarding through the RF.
- **Flag clear:**
  - Stimulus: after a sub producing cf=1, issue (xor, rd=3, rs1=1, rs2=1).
  - Response: `res_data`=0, `flags`={0,0,1}.
- **Full FIFO:**
  - Stimulus: `hold`=1, push `DEPTH` commands.
  - Response: `cmd_ready`=0 after the 4th push and the 5th command is not accepted.
  - Stimulus: release `hold`.
  - Response: 4 consecutive `res_valid` cycles in FIFO order; `cmd_ready` rises in the cycle after the first pop.
- **Hold mid-stream:** assert `hold` while in EXEC with 2 commands queued → the current op completes (1 pulse), FSM goes to IDLE, and the 2 commands stay queued until `hold`=0.
- **Compare ops:**
  - Stimulus: rf[1]=1111, rf[2]=0001; (110, rd=3, rs1=1, rs2=2), then (111, rd=0, rs1=2, rs2=2).
  - Response: rf[3]=0001, rf[0]=0001.
